// File: rtl/arb8_rr_sched.sv
// Round-robin scheduler granting one of eight requesters to a shared 3-to-8 decoder.
// Ownership is held until release or HOLD_MAX cycles, with one idle cycle between owners.
module arb8_rr_sched #(
   parameter int HOLD_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   input  logic       done,
   output logic [2:0] gnt_idx,
   output logic       gnt_en,
   output logic [7:0] gnt,
   output logic       timeout,
   output logic [2:0] ptr
);

   localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t      state, state_nxt;
   logic [2:0]  ptr_nxt, idx_nxt, win_idx;
   logic [7:0]  hold_cnt, hold_nxt;
   logic        timeout_nxt;
   logic [15:0] req2;
   logic [7:0]  rot;

   // Rotate requests so that bit 0 of rot is the requester at ptr.
   always_comb begin
      req2    = {req, req};
      rot     = 8'(req2 >> ptr);
      win_idx = ptr;
      for (int i = 7; i >= 0; i--) begin
         if (rot[i]) win_idx = ptr + 3'(i);
      end
   end

   // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
   always_comb begin
      state_nxt   = state;
      ptr_nxt     = ptr;
      idx_nxt     = gnt_idx;
      hold_nxt    = hold_cnt;
      timeout_nxt = 1'b0;
      case (state)
         IDLE: begin
            if (|req) begin
               state_nxt = GRANT;
               idx_nxt   = win_idx;
               hold_nxt  = 8'd0;
            end
         end
         GRANT: begin
            if (done || !req[gnt_idx]) begin
               state_nxt = IDLE;
               ptr_nxt   = gnt_idx + 3'd1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nxt   = IDLE;
               ptr_nxt     = gnt_idx + 3'd1;
               timeout_nxt = 1'b1;
            end else begin
               hold_nxt = hold_cnt + 8'd1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         ptr      <= 3'd0;
         gnt_idx  <= 3'd0;
         hold_cnt <= 8'd0;
         timeout  <= 1'b0;
      end else begin
         state    <= state_nxt;
         ptr      <= ptr_nxt;
         gnt_idx  <= idx_nxt;
         hold_cnt <= hold_nxt;
         timeout  <= timeout_nxt;
      end
   end

   assign gnt_en = (state == GRANT);
   assign gnt    = gnt_en ? (8'b1 << gnt_idx) : 8'b0;

endmodule

// File: tb/tb_arb8_rr_sched.sv
// Directed bench for arb8_rr_sched (HOLD_MAX=4): vector table plus rotation and reset sequences.
module tb_arb8_rr_sched;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic       done;
   logic [2:0] gnt_idx;
   logic       gnt_en;
   logic [7:0] gnt;
   logic       timeout;
   logic [2:0] ptr;

   int checks = 0;
   int errors = 0;

   arb8_rr_sched #(.HOLD_MAX(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .done    (done),
      .gnt_idx (gnt_idx),
      .gnt_en  (gnt_en),
      .gnt     (gnt),
      .timeout (timeout),
      .ptr     (ptr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] req;
      logic       done;
      logic       en;
      logic [2:0] idx;
      logic [7:0] gnt;
      logic       to;
      logic [2:0] ptr;
   } vec_t;

   vec_t vq[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   function automatic vec_t mk(logic [7:0] r, logic d, logic e, logic [2:0] i,
                               logic [7:0] g, logic t, logic [2:0] p);
      vec_t v;
      v.req = r; v.done = d; v.en = e; v.idx = i; v.gnt = g; v.to = t; v.ptr = p;
      return v;
   endfunction

   initial begin
      // inputs applied before an edge; expected outputs seen just after it
      //              req   done en idx gnt    to ptr
      vq.push_back(mk(8'h04, 0, 1, 2, 8'h04, 0, 0)); // single requester
      vq.push_back(mk(8'h04, 0, 1, 2, 8'h04, 0, 0));
      vq.push_back(mk(8'h04, 0, 1, 2, 8'h04, 0, 0));
      vq.push_back(mk(8'h00, 0, 0, 2, 8'h00, 0, 3)); // dropped -> ptr=3
      vq.push_back(mk(8'h00, 0, 0, 2, 8'h00, 0, 3));
      vq.push_back(mk(8'h20, 0, 1, 5, 8'h20, 0, 3)); // set up ptr=6
      vq.push_back(mk(8'h20, 1, 0, 5, 8'h00, 0, 6));
      vq.push_back(mk(8'h05, 0, 1, 0, 8'h01, 0, 6)); // fairness skip 6,7,0
      vq.push_back(mk(8'h05, 1, 0, 0, 8'h00, 0, 1));
      vq.push_back(mk(8'h05, 0, 1, 2, 8'h04, 0, 1));
      vq.push_back(mk(8'h05, 1, 0, 2, 8'h00, 0, 3));
      vq.push_back(mk(8'h05, 0, 1, 0, 8'h01, 0, 3));
      vq.push_back(mk(8'h05, 1, 0, 0, 8'h00, 0, 1));
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 1)); // timeout, 4 grant cycles
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 1));
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 1));
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 1));
      vq.push_back(mk(8'h80, 0, 0, 7, 8'h00, 1, 0)); // forced release
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 0)); // re-grant after one idle
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 0));
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 0));
      vq.push_back(mk(8'h80, 0, 1, 7, 8'h80, 0, 0)); // 4th grant cycle
      vq.push_back(mk(8'h80, 1, 0, 7, 8'h00, 0, 0)); // done wins over limit
      vq.push_back(mk(8'h00, 1, 0, 7, 8'h00, 0, 0)); // done in IDLE ignored
      vq.push_back(mk(8'h00, 0, 0, 7, 8'h00, 0, 0));
      vq.push_back(mk(8'h02, 0, 1, 1, 8'h02, 0, 0)); // no pre-emption
      vq.push_back(mk(8'h03, 0, 1, 1, 8'h02, 0, 0));
      vq.push_back(mk(8'h01, 0, 0, 1, 8'h00, 0, 2));

      rst  = 1'b1;
      req  = 8'h00;
      done = 1'b0;
      #2;
      check("rst_gnt_en", 32'(gnt_en), 32'd0);
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_timeout", 32'(timeout), 32'd0);
      check("rst_ptr", 32'(ptr), 32'd0);
      check("rst_gnt_idx", 32'(gnt_idx), 32'd0);

      do_reset();
      foreach (vq[i]) begin
         req  = vq[i].req;
         done = vq[i].done;
         step();
         check($sformatf("v%0d_en", i), 32'(gnt_en), 32'(vq[i].en));
         check($sformatf("v%0d_idx", i), 32'(gnt_idx), 32'(vq[i].idx));
         check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(vq[i].gnt));
         check($sformatf("v%0d_to", i), 32'(timeout), 32'(vq[i].to));
         check($sformatf("v%0d_ptr", i), 32'(ptr), 32'(vq[i].ptr));
      end

      // Full rotation: all request, done pulsed in each grant's first cycle.
      do_reset();
      req = 8'hFF;
      for (int k = 0; k < 9; k++) begin
         done = 1'b0;
         step();
         check($sformatf("rot%0d_en", k), 32'(gnt_en), 32'd1);
         check($sformatf("rot%0d_idx", k), 32'(gnt_idx), 32'(k % 8));
         check($sformatf("rot%0d_gnt", k), 32'(gnt), 32'(8'b1 << (k % 8)));
         done = 1'b1;
         step();
         check($sformatf("rot%0d_gap", k), 32'(gnt_en), 32'd0);
         check($sformatf("rot%0d_ptr", k), 32'(ptr), 32'((k + 1) % 8));
      end

      // Reset mid-grant with owner 5; outputs must clear before any edge.
      done = 1'b0;
      req  = 8'h20;
      step();
      check("pre_rst_idx", 32'(gnt_idx), 32'd5);
      check("pre_rst_gnt", 32'(gnt), 32'h20);
      #1 rst = 1'b1;
      #1;
      check("async_gnt", 32'(gnt), 32'd0);
      check("async_en", 32'(gnt_en), 32'd0);
      check("async_ptr", 32'(ptr), 32'd0);
      #1 rst = 1'b0;
      step();
      check("post_rst_gnt", 32'(gnt), 32'h20);
      check("post_rst_idx", 32'(gnt_idx), 32'd5);
      check("post_rst_ptr", 32'(ptr), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arb8_rr_sched.md
# arb8_rr_sched

Round-robin scheduler that shares one 3-to-8 decoded resource among eight requesters. It sequences ownership: it picks one requester, presents its index and enable to the decoder stage, and holds the grant until the owner releases or a hold limit expires. Pointer-based rotation gives fair service. It sits between the requester bank and the decoder-driven select lines.

## Interface
- `HOLD_MAX`, default 15: maximum consecutive cycles one owner may hold the grant. Legal range is 1..255.
- `clk` input 1: system clock. All state changes on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req` input [7:0]: request lines. `req[i]` high means requester i wants the resource.
- `done` input 1: the current owner is finished. Sampled only in GRANT.
- `gnt_idx` output [2:0]: index of the current owner. Drives the decoder select.
- `gnt_en` output 1: grant valid. Drives the decoder enable.
- `gnt` output [7:0]: one-hot grant. Equals `1 << gnt_idx` when `gnt_en`=1, otherwise 0.
- `timeout` output 1: one-cycle pulse when a grant is force-released by the hold limit.
- `ptr` output [2:0]: current round-robin priority pointer, for debug and verification.

## Operation
- Internal state:
  - FSM with states IDLE and GRANT.
  - `ptr` [2:0] and `hold_cnt` [7:0], both registered.
- IDLE:
  - If `req` is 0, stay in IDLE.
  - Otherwise, search `req` in order ptr, ptr+1, … ptr+7, taking each index mod 8. The first set bit becomes the winner.
  - Register the winner into `gnt_idx`, set `hold_cnt` to 0, and go to GRANT.
- GRANT release checks are evaluated every cycle, highest priority first:
  1. `done`=1 or `req[gnt_idx]`=0: normal release.
  2. `hold_cnt` == HOLD_MAX-1: forced release. The next cycle has `timeout`=1.
  3. Otherwise stay in GRANT and increment `hold_cnt`.
- On any release:
  - Next state is IDLE.
  - `ptr` becomes `gnt_idx`+1, modulo 8, so 7 wraps to 0.
  - `gnt_idx` keeps its last value. `gnt_en` and `gnt` drop to 0.
- IDLE always lasts at least one cycle after a release, so there is never back-to-back ownership without a gap. This gives the decoder one cycle of `out`=0 between owners.
- `gnt` is decoded combinationally from the registered `gnt_idx` and `gnt_en`. It is 0 whenever `gnt_en`=0 and is never multi-hot.
- `done` asserted in IDLE is ignored.
- Requests that change while in GRANT do not pre-empt the owner. Only the owner's own `req` bit matters.
- Simultaneous normal release and hold limit (rule 1 and rule 2 in the same cycle): normal release wins and `timeout` is not pulsed.
- HOLD_MAX=1: every grant lasts exactly one cycle. `timeout` pulses only if the owner still requests without `done`.

## Timing
- Reset values, applied asynchronously:
  - state = IDLE, `ptr` = 0, `gnt_idx` = 0, `hold_cnt` = 0.
  - `gnt_en` = 0, `gnt` = 0, `timeout` = 0.
- Request-to-grant latency is 1 cycle. A `req` bit sampled at edge N in IDLE gives `gnt_en`=1 after edge N.
- Release latency is 1 cycle. A release condition true before edge N gives `gnt_en`=0 after edge N.
- Maximum grant length is HOLD_MAX cycles of `gnt_en`=1.
- `timeout` is registered. It is high only in the first IDLE cycle after a forced release.
- Minimum period between grants is 2 cycles: one GRANT cycle plus one IDLE cycle.
- Reset mid-grant: outputs clear immediately, without waiting for a clock edge. The first grant after reset deasserts searches from index 0.

## Test plan
- **Reset:** assert `rst` mid-GRANT with `gnt_idx`=5 → `gnt`=0 and `gnt_en`=0 immediately. After release, `req`=8'h20 → `gnt`=8'h20 one cycle later.
- **Single requester:** `req`=8'h04 held for 3 cycles, then dropped → `gnt_idx`=2 and `gnt`=8'h04 for 3 cycles, then 0. `ptr`=3 afterwards.
- **Full rotation:**
  - Setup: `req`=8'hFF held, `done` pulsed in each grant's first cycle.
  - Required: grants go 0,1,2,…,7,0 with one IDLE cycle between grants.
  - `ptr` wraps 7→0.
- **Fairness skip:** `ptr`=6, `req`=8'h05 → grant index 0 (search 6,7,0), then index 2, then index 0.
- **Timeout:** HOLD_MAX=4, `req`=8'h80 held, `done`=0 → `gnt`=8'h80 for exactly 4 cycles. `timeout`=1 for 1 cycle, `ptr`=0. Index 7 is re-granted after one IDLE cycle.
- **Simultaneous events:** HOLD_MAX=4, `done`=1 in the 4th GRANT cycle → release with `timeout`=0.
